neuron_mac: RTL
===============

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed width of inputs, weights, bias and out.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of the Q-format shared by all data.
REQ-003 Parameter NUM_INPUTS, default 16: inputs per neuron; must be a multiple of LANES.
REQ-004 Parameter LANES, default 4: multiplies per cycle; legal values 1..NUM_INPUTS.
REQ-005 Parameter ACTIVATION, default relu: activation_type, one of relu, identity or leaky_relu.
REQ-006 Ports: clock input 1, the single clock; reset input 1, asynchronous, active-high.
REQ-007 Ports: input_valid input 1; input_ready output 1; inputs input NUM_INPUTS x DATA_WIDTH signed.
REQ-008 Ports: weight_write input 1; weight_address input clog2(NUM_INPUTS); weight_data input DATA_WIDTH signed.
REQ-009 Ports: bias_write input 1; bias_data input DATA_WIDTH signed.
REQ-010 Ports: out output DATA_WIDTH signed; output_valid output 1; output_accept input 1; saturated output 1.

Function
REQ-011 FSM states SHALL be waiting, computing, activating and done.
- waiting->computing on input_valid && input_ready.
- computing->activating after NUM_INPUTS/LANES cycles.
- activating->done unconditionally.
- done->waiting on output_accept.
REQ-012 input_ready SHALL be 1 only in waiting; output_valid SHALL be 1 only in done.
REQ-013 On the acceptance edge, inputs SHALL be latched, the accumulator cleared and the chunk counter zeroed.
REQ-014 Each computing cycle SHALL add the LANES products of chunk k (elements k*LANES..k*LANES+LANES-1) to the accumulator, then increment k.
REQ-015 Products SHALL be 2*DATA_WIDTH bits signed; the accumulator SHALL be 2*DATA_WIDTH+clog2(NUM_INPUTS)+1 bits signed; no intermediate overflow is possible.
REQ-016 Activating SHALL compute r = (acc + (bias <<< FRAC_BITS)) >>> FRAC_BITS, an arithmetic shift that floors toward minus infinity.
REQ-017 Activation of r: relu gives max(r,0); identity gives r; leaky_relu gives r when r>=0, else r>>>3.
REQ-018 The activation result SHALL be saturated to the DATA_WIDTH signed range, registered into out, and saturated set to 1 iff clipping occurred.
REQ-019 output_valid SHALL rise NUM_INPUTS/LANES+1 edges after the acceptance edge.
REQ-020 out and saturated SHALL hold stable while output_valid=1 and output_accept=0; input_valid SHALL be ignored outside waiting.
REQ-021 weight_write and bias_write SHALL take effect only in waiting and be silently ignored in every other state.
REQ-022 A write coincident with the acceptance edge SHALL be committed and used by that computation.
REQ-023 Simultaneous weight_write and bias_write SHALL both commit.

Reset
REQ-024 Reset SHALL force the following values, with immediate effect at any time including mid-computation, with no partial result emitted: state waiting; out 0; saturated 0; output_valid 0; accumulator 0; counter 0; all weights 0; bias 0.
REQ-025 After reset deassertion, input_ready SHALL be 1 on the first clock.

Structure
REQ-026 Package neuron_pkg SHALL hold activation_type {relu, identity, leaky_relu} and shared fixed-point helpers; the module imports it.
REQ-027 Sub-module neuron_activator (combinational: bias add, shift, activation, saturation, saturated flag) SHALL be instantiated once.
REQ-028 An elaboration-time check SHALL reject NUM_INPUTS % LANES != 0.

Verification (DATA_WIDTH=16, FRAC_BITS=8, NUM_INPUTS=4, LANES=2 unless stated)
REQ-029 Basic: weights all 256 (1.0), bias 128, inputs 256/512/768/1024.
- Required: out=2688 (10.5), saturated=0.
- Required: output_valid exactly 3 edges after acceptance.
REQ-030 Relu and leaky_relu: weights 256, bias 0, inputs all -256.
- relu: out=0.
- leaky_relu: out=-128 (-1024>>>3).
REQ-031 Saturation: weights 32767, inputs 32767, bias 32767 -> out=32767, saturated=1.
- Negating the inputs with ACTIVATION=identity -> out=-32768, saturated=1.
REQ-032 Backpressure: output_accept held 0 for 5 cycles -> out held constant, input_ready=0.
- Accept asserted -> waiting on next edge, input_ready=1.
REQ-033 Ignored writes and reset: weight_write (address 0, data 0) during computing -> no change.
- Next run with inputs 256 x4, weights 256, bias 0 -> out=1024.
- Reset pulsed mid-computing -> out=0, output_valid=0, weights read as 0 on next run (out=0).
REQ-034 Sweep: LANES=1 and LANES=4 with the REQ-029 stimulus -> out=2688.
- Required latencies: 5 edges (LANES=1) and 2 edges (LANES=4).

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the fixed-point neuron datapath.
package neuron_pkg;

    typedef enum logic [1:0] {relu, identity, leaky_relu} activation_type;

    typedef enum logic [1:0] {waiting, computing, activating, done} state_t;

    // Wide enough for NUM_INPUTS full-scale products plus sign, so the sum cannot wrap.
    function automatic int acc_width(input int data_width, input int num_inputs);
        return 2 * data_width + $clog2(num_inputs) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_activator.sv
// Combinational: bias add, Q-format rescale (floor), activation, saturation.
// Zero latency; no flow control.
module neuron_activator
    import neuron_pkg::*;
#(
    parameter int             DATA_WIDTH = 16,
    parameter int             FRAC_BITS  = 8,
    parameter int             ACC_WIDTH  = 37,
    parameter activation_type ACTIVATION = relu
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         saturated
);

    localparam int W = ACC_WIDTH + 1;
    localparam logic signed [W-1:0] MAX_V = {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [W-1:0] acc_x;
    logic signed [W-1:0] bias_x;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] r;
    logic signed [W-1:0] act;

    always_comb begin
        acc_x  = {acc[ACC_WIDTH-1], acc};
        bias_x = {{(W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
        sum    = acc_x + (bias_x <<< FRAC_BITS);
        r      = sum >>> FRAC_BITS;
        act    = r;
        case (ACTIVATION)
            relu:       act = r[W-1] ? '0 : r;
            leaky_relu: act = r[W-1] ? (r >>> 3) : r;
            default:    act = r;
        endcase
        result    = act[DATA_WIDTH-1:0];
        saturated = 1'b0;
        if (act > MAX_V) begin
            result    = MAX_V[DATA_WIDTH-1:0];
            saturated = 1'b1;
        end else if (act < MIN_V) begin
            result    = MIN_V[DATA_WIDTH-1:0];
            saturated = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: LANES multiply-accumulates per cycle, then activation; result valid NUM_INPUTS/LANES+1 edges after accept.
// Holds out/saturated in done until output_accept; input_ready only while waiting.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int             DATA_WIDTH = 16,
    parameter int             FRAC_BITS  = 8,
    parameter int             NUM_INPUTS = 16,
    parameter int             LANES      = 4,
    parameter activation_type ACTIVATION = relu
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   input_valid,
    output logic                                   input_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs,
    input  logic                                   weight_write,
    input  logic [idx_width(NUM_INPUTS)-1:0]       weight_address,
    input  logic signed [DATA_WIDTH-1:0]           weight_data,
    input  logic                                   bias_write,
    input  logic signed [DATA_WIDTH-1:0]           bias_data,
    output logic signed [DATA_WIDTH-1:0]           out,
    output logic                                   output_valid,
    input  logic                                   output_accept,
    output logic                                   saturated
);

    localparam int CHUNKS = NUM_INPUTS / LANES;
    localparam int ACC_W  = acc_width(DATA_WIDTH, NUM_INPUTS);
    localparam int IW     = idx_width(NUM_INPUTS);
    localparam int CW     = idx_width(CHUNKS);

    if ((NUM_INPUTS % LANES) != 0 || LANES < 1 || LANES > NUM_INPUTS) begin : g_bad_lanes
        $error("neuron_mac: LANES must divide NUM_INPUTS and lie in 1..NUM_INPUTS");
    end

    state_t                       state;
    state_t                       state_nxt;
    logic signed [DATA_WIDTH-1:0] weights [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] data_q  [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      chunk_sum;
    logic [CW-1:0]                chunk;
    logic signed [DATA_WIDTH-1:0] act_result;
    logic                         act_sat;
    logic                         accept;
    logic [IW-1:0]                idx;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign input_ready  = (state == waiting);
    assign output_valid = (state == done);
    assign accept       = input_valid && input_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            waiting:    if (input_valid) state_nxt = computing;
            computing:  if (chunk == CW'(CHUNKS - 1)) state_nxt = activating;
            activating: state_nxt = done;
            done:       if (output_accept) state_nxt = waiting;
            default:    state_nxt = waiting;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= waiting;
        else       state <= state_nxt;
    end

    // Elements chunk*LANES .. chunk*LANES+LANES-1 of the latched vector.
    always_comb begin
        chunk_sum = '0;
        idx       = '0;
        prod      = '0;
        for (int l = 0; l < LANES; l++) begin
            idx       = IW'(int'(chunk) * LANES + l);
            prod      = (2*DATA_WIDTH)'(weights[idx]) * (2*DATA_WIDTH)'(data_q[idx]);
            chunk_sum = chunk_sum + ACC_W'(prod);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_INPUTS; j++) begin
                weights[j] <= '0;
                data_q[j]  <= '0;
            end
            bias      <= '0;
            acc       <= '0;
            chunk     <= '0;
            out       <= '0;
            saturated <= 1'b0;
        end else begin
            // Writes landing on the acceptance edge are visible to that computation.
            if (state == waiting) begin
                if (weight_write) weights[weight_address] <= weight_data;
                if (bias_write)   bias <= bias_data;
            end
            if (accept) begin
                for (int j = 0; j < NUM_INPUTS; j++) data_q[j] <= inputs[j];
                acc   <= '0;
                chunk <= '0;
            end else if (state == computing) begin
                acc   <= acc + chunk_sum;
                chunk <= chunk + 1'b1;
            end
            if (state == activating) begin
                out       <= act_result;
                saturated <= act_sat;
            end
        end
    end

    neuron_activator #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_W),
        .ACTIVATION (ACTIVATION)
    ) u_activator (
        .acc       (acc),
        .bias      (bias),
        .result    (act_result),
        .saturated (act_sat)
    );

endmodule
